// File: rtl/rs544522_lal7_syndrome.sv
// rtl/rs544522_lal7_syndrome.sv - 7-lane RS(544,522) syndrome calculator over GF(2^10)
module rs544522_lal7_syndrome #(
   parameter int W     = 10,
   parameter int R     = 22,
   parameter int L     = 7,
   parameter int BEATS = 78
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         valid_i,
   input  logic         last_i,
   input  logic [W-1:0] r_blk_i [0:L-1],
   output logic         syn_valid_o,
   output logic [W-1:0] syn_o [0:R-1],
   output logic         clean_o,
   output logic         len_err_o
);

   // Flat GF(2^10) product, field polynomial x^10 + x^3 + 1
   function automatic logic [W-1:0] gf1024_mul_pb_k5_flat(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] p;
      logic [W-1:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < W; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[W-2:0], 1'b0} ^ (x[W-1] ? 10'h009 : 10'h000);
      end
      return p;
   endfunction

   function automatic logic [W-1:0] gf_pow(input int e);
      logic [W-1:0] r;
      logic [W-1:0] b;
      r = 10'h001;
      b = 10'h002;
      for (int i = 0; i < 11; i++) begin
         if (e[i]) r = gf1024_mul_pb_k5_flat(r, b);
         b = gf1024_mul_pb_k5_flat(b, b);
      end
      return r;
   endfunction

   function automatic logic [R*W-1:0] gen_alpha_l();
      logic [R*W-1:0] v;
      v = '0;
      for (int j = 0; j < R; j++) v[j*W +: W] = gf_pow(L * j);
      return v;
   endfunction

   function automatic logic [L*R*W-1:0] gen_alpha_k();
      logic [L*R*W-1:0] v;
      v = '0;
      for (int k = 0; k < L; k++)
         for (int j = 0; j < R; j++)
            v[(k*R + j)*W +: W] = gf_pow(j * (L - 1 - k));
      return v;
   endfunction

   localparam logic [R*W-1:0]   ALPHA_L = gen_alpha_l();
   localparam logic [L*R*W-1:0] ALPHA_K = gen_alpha_k();

   typedef enum logic {IDLE, ACC} state_t;

   state_t       state_q, state_d;
   logic [W-1:0] acc_q  [0:R-1];
   logic [W-1:0] horner [0:R-1];
   logic [6:0]   cnt_q;
   logic         accept, publish, all_zero, len_err_d;

   always_comb begin
      all_zero = 1'b1;
      for (int j = 0; j < R; j++) begin
         horner[j] = start_i ? '0 : gf1024_mul_pb_k5_flat(acc_q[j], ALPHA_L[j*W +: W]);
         for (int k = 0; k < L; k++)
            horner[j] = horner[j] ^ gf1024_mul_pb_k5_flat(r_blk_i[k], ALPHA_K[(k*R + j)*W +: W]);
         if (horner[j] != '0) all_zero = 1'b0;
      end
      // A start beat is always beat index 0, even when it restarts a frame
      len_err_d = ((start_i ? 7'd0 : cnt_q) != 7'(BEATS - 1));
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      publish = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_i && start_i) begin
               accept = 1'b1;
               if (last_i) publish = 1'b1;
               else        state_d = ACC;
            end
         end
         ACC: begin
            if (valid_i) begin
               accept = 1'b1;
               if (last_i) begin
                  publish = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int j = 0; j < R; j++) begin
            acc_q[j] <= '0;
            syn_o[j] <= '0;
         end
         cnt_q       <= '0;
         syn_valid_o <= 1'b0;
         clean_o     <= 1'b0;
         len_err_o   <= 1'b0;
      end else begin
         syn_valid_o <= publish;
         if (accept) begin
            acc_q <= horner;
            if (publish)           cnt_q <= '0;
            else if (start_i)      cnt_q <= 7'd1;
            else if (cnt_q != '1)  cnt_q <= cnt_q + 7'd1;
         end
         if (publish) begin
            syn_o     <= horner;
            len_err_o <= len_err_d;
            clean_o   <= all_zero & ~len_err_d;
         end
      end
   end

endmodule

// File: tb/tb_rs544522_lal7_syndrome.sv
// tb/tb_rs544522_lal7_syndrome.sv - directed/random bench with direct-evaluation syndrome model
module tb_rs544522_lal7_syndrome;
   localparam int W = 10, R = 22, L = 7, BEATS = 78, NSYM = BEATS * L;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic         start_i = 1'b0, valid_i = 1'b0, last_i = 1'b0;
   logic [W-1:0] r_blk_i [0:L-1];
   logic         syn_valid_o, clean_o, len_err_o;
   logic [W-1:0] syn_o [0:R-1];

   rs544522_lal7_syndrome dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .valid_i(valid_i), .last_i(last_i),
      .r_blk_i(r_blk_i), .syn_valid_o(syn_valid_o), .syn_o(syn_o), .clean_o(clean_o),
      .len_err_o(len_err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0, failures = 0, pulses = 0;
   int gexp [0:1022];
   int glog [0:1023];
   logic [W-1:0] frm  [0:NSYM-1];
   logic [W-1:0] good [0:NSYM-1];
   int gpoly [0:R];

   always @(negedge clk_i) if (syn_valid_o === 1'b1) pulses++;

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[(glog[a] + glog[b]) % 1023];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic beat(input bit s, input bit l, input int b);
      valid_i = 1'b1; start_i = s; last_i = l;
      for (int k = 0; k < L; k++) r_blk_i[k] = frm[b*L + k];
      @(posedge clk_i); #1;
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0;
      repeat (n) begin @(posedge clk_i); #1; end
   endtask

   // nb beats of frm; gap idle cycles between beats; ends right after the last-beat edge
   task automatic run_frame(input int nb, input int gap);
      for (int b = 0; b < nb; b++) begin
         beat(b == 0, b == nb - 1, b);
         if (gap > 0 && b != nb - 1) idle(gap);
      end
   endtask

   // Syndromes by direct evaluation of r(alpha^j) over the first nb beats
   task automatic check_result(input string tag, input int nb, input bit exp_len);
      int s;
      bit allz;
      allz = 1'b1;
      chk({tag, "_valid"}, syn_valid_o, 1);
      for (int j = 0; j < R; j++) begin
         s = 0;
         for (int i = 0; i < nb * L; i++)
            s = s ^ gmul(frm[i], gexp[(j * (nb * L - 1 - i)) % 1023]);
         if (s != 0) allz = 1'b0;
         chk($sformatf("%s_S%0d", tag, j), syn_o[j], s);
      end
      chk({tag, "_len_err"}, len_err_o, exp_len);
      chk({tag, "_clean"}, clean_o, allz & ~exp_len);
   endtask

   task automatic encode_random();
      int m [0:521];
      int rem [0:R-1];
      int fb;
      for (int i = 0; i < 522; i++) m[i] = $urandom_range(1023);
      for (int i = 0; i < R; i++) rem[i] = 0;
      for (int i = 0; i < 522; i++) begin
         fb = m[i] ^ rem[R-1];
         for (int d = R - 1; d > 0; d--) rem[d] = rem[d-1] ^ gmul(fb, gpoly[d]);
         rem[0] = gmul(fb, gpoly[0]);
      end
      good[0] = '0; good[1] = '0;
      for (int i = 0; i < 522; i++) good[2 + i] = W'(m[i]);
      for (int i = 0; i < R; i++) good[2 + 522 + i] = W'(rem[R-1-i]);
   endtask

   task automatic load_good();
      for (int i = 0; i < NSYM; i++) frm[i] = good[i];
   endtask

   initial begin
      int x, p0;
      x = 1;
      for (int i = 0; i < 1023; i++) begin
         gexp[i] = x; glog[x] = i;
         x = x << 1;
         if (x >= 1024) x = x ^ 'h409;
      end
      for (int i = 0; i <= R; i++) gpoly[i] = 0;
      gpoly[0] = 1;
      for (int j = 0; j < R; j++)
         for (int i = j + 1; i >= 0; i--)
            gpoly[i] = (i > 0 ? gpoly[i-1] : 0) ^ gmul(gpoly[i], gexp[j]);
      for (int k = 0; k < L; k++) r_blk_i[k] = '0;

      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_valid", syn_valid_o, 0);
      chk("rst_clean", clean_o, 0);
      chk("rst_len_err", len_err_o, 0);
      chk("rst_S0", syn_o[0], 0);
      rst_ni = 1'b1;
      idle(2);

      for (int i = 0; i < NSYM; i++) frm[i] = '0;
      run_frame(BEATS, 0);
      check_result("zero", BEATS, 0);
      chk("zero_clean_const", clean_o, 1);
      idle(1);
      chk("pulse_one_cycle", syn_valid_o, 0);

      encode_random();
      load_good();
      run_frame(BEATS, 0);
      check_result("codeword", BEATS, 0);
      chk("codeword_clean_const", clean_o, 1);
      idle(2);

      frm[NSYM-1] = frm[NSYM-1] ^ 10'h001;
      run_frame(BEATS, 0);
      check_result("flip_x0", BEATS, 0);
      chk("flip_x0_S0", syn_o[0], 1);
      chk("flip_x0_S21", syn_o[R-1], 1);
      idle(1);

      load_good();
      frm[2] = frm[2] ^ 10'h001;
      run_frame(BEATS, 0);
      check_result("flip_x543", BEATS, 0);
      chk("flip_x543_S0", syn_o[0], 1);
      chk("flip_x543_S1", syn_o[1], gexp[543]);
      idle(1);

      load_good();
      run_frame(51, 0);
      check_result("short51", 51, 1);
      run_frame(BEATS, 0);
      check_result("b2b_good", BEATS, 0);
      idle(1);

      for (int i = 0; i < NSYM; i++) frm[i] = W'($urandom_range(1023));
      p0 = pulses;
      for (int b = 0; b < 30; b++) beat(b == 0, 1'b0, b);
      load_good();
      run_frame(BEATS, 0);
      check_result("restart_B", BEATS, 0);
      idle(1);
      chk("restart_pulses", pulses - p0, 1);

      run_frame(BEATS, 3);
      check_result("gapped_B", BEATS, 0);
      idle(1);

      for (int n = 0; n < 2; n++) begin
         for (int i = 0; i < NSYM; i++) frm[i] = W'($urandom_range(1023));
         run_frame(BEATS, n);
         check_result($sformatf("rand%0d", n), BEATS, 0);
         idle(1);
      end

      frm[0] = 10'h155;
      run_frame(1, 0);
      check_result("single_beat", 1, 1);
      idle(1);

      for (int i = 0; i < NSYM; i++) frm[i] = W'($urandom_range(1023));
      run_frame(BEATS, 0);
      check_result("pre_reset", BEATS, 0);
      for (int b = 0; b < 40; b++) beat(b == 0, 1'b0, b);
      #2 rst_ni = 1'b0;
      #1;
      chk("async_rst_S0", syn_o[0], 0);
      chk("async_rst_clean", clean_o, 0);
      chk("async_rst_len_err", len_err_o, 0);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;
      p0 = pulses;
      for (int b = 40; b < BEATS; b++) beat(1'b0, b == BEATS - 1, b);
      idle(2);
      chk("post_rst_no_pulse", pulses - p0, 0);
      chk("post_rst_valid", syn_valid_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
